// File: rtl/uart_chk_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_chk_pkg
// Purpose  : Shared types, constants and helpers for the UART echo checker.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_chk_pkg;

  localparam int CNT_W = 16;

  // Feedback taps l[7]^l[5]^l[4]^l[3]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_NEXT  = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_chk_lfsr.sv
//------------------------------------------------------------------------------
// Module   : uart_chk_lfsr
// Purpose  : 8-bit Fibonacci LFSR with synchronous load of the seed.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_chk_lfsr
  import uart_chk_pkg::*;
(
  input  logic       clk_out1,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clk_out1) begin
    if (rst) begin
      value_q <= seed;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

`default_nettype wire

// File: rtl/uart_echo_checker.sv
//------------------------------------------------------------------------------
// Module   : uart_echo_checker
// Purpose  : Sends an LFSR byte stream to uart_tx, checks each echo from
//            uart_rx, and counts passes, mismatches and timeouts.
//            Optional stray-echo counter: define UART_CHK_STRAY_CNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_echo_checker
  import uart_chk_pkg::*;
#(
  parameter int         NUM_BYTES      = 16,
  parameter int         TIMEOUT_CYCLES = 2_000_000,
  parameter logic [7:0] SEED           = 8'hA5
) (
  input  logic        clk_out1,
  input  logic        rst,
  input  logic        start,
  output logic        tx_data_en,
  output logic [7:0]  tx_data_in,
  input  logic        tx_finish,
  input  logic        rx_finish,
  input  logic [7:0]  rx_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] pass_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] timeout_cnt,
  output logic [7:0]  last_err_exp,
  output logic [7:0]  last_err_got
`ifdef UART_CHK_STRAY_CNT_EN
  ,
  output logic [15:0] stray_cnt
`endif
);

  localparam int               TMR_W    = 32;
  localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0]      IDX_LAST = 16'(NUM_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic             tx_en_q, tx_en_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] to_q, to_d;
  logic [7:0]       exp_q, exp_d;
  logic [7:0]       got_q, got_d;
  logic             tx_ok_q, tx_ok_d;
  logic             rx_ok_q, rx_ok_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [15:0]      idx_q, idx_d;
  logic             tx_ok_n, rx_ok_n;
  logic             lfsr_load, lfsr_step;
  logic [7:0]       lfsr_val;

  uart_chk_lfsr u_lfsr (
    .clk_out1 (clk_out1),
    .rst      (rst),
    .load     (lfsr_load),
    .step     (lfsr_step),
    .seed     (SEED_EFF),
    .value    (lfsr_val)
  );

  always_comb begin
    state_d   = state_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    to_d      = to_q;
    exp_d     = exp_q;
    got_d     = got_q;
    tx_ok_d   = tx_ok_q;
    rx_ok_d   = rx_ok_q;
    rx_byte_d = rx_byte_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    tx_ok_n   = tx_ok_q | tx_finish;
    rx_ok_n   = rx_ok_q | rx_finish;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pass_d    = '0;
          err_d     = '0;
          to_d      = '0;
          exp_d     = '0;
          got_d     = '0;
          idx_d     = '0;
          lfsr_load = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_data_d = lfsr_val;
        tx_en_d   = 1'b1;
        tx_ok_d   = 1'b0;
        rx_ok_d   = 1'b0;
        timer_d   = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        tx_ok_d = tx_ok_n;
        rx_ok_d = rx_ok_n;
        // Only the first echo of this byte is captured.
        if (rx_finish && !rx_ok_q) begin
          rx_byte_d = rx_data;
        end
        if (tx_ok_n && rx_ok_n) begin
          state_d = ST_CHECK;
        end else if (timer_q == TMR_LAST) begin
          if (rx_ok_n) begin
            state_d = ST_CHECK;
          end else begin
            to_d    = sat_inc(to_q);
            state_d = ST_NEXT;
          end
        end
      end
      ST_CHECK: begin
        if (rx_byte_q == tx_data_q) begin
          pass_d = sat_inc(pass_q);
        end else begin
          err_d = sat_inc(err_q);
          exp_d = tx_data_q;
          got_d = rx_byte_q;
        end
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == IDX_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d     = idx_q + 16'd1;
          lfsr_step = 1'b1;
          state_d   = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_out1) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= '0;
      err_q     <= '0;
      to_q      <= '0;
      exp_q     <= '0;
      got_q     <= '0;
      tx_ok_q   <= 1'b0;
      rx_ok_q   <= 1'b0;
      rx_byte_q <= '0;
      timer_q   <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      to_q      <= to_d;
      exp_q     <= exp_d;
      got_q     <= got_d;
      tx_ok_q   <= tx_ok_d;
      rx_ok_q   <= rx_ok_d;
      rx_byte_q <= rx_byte_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
    end
  end

  assign tx_data_en   = tx_en_q;
  assign tx_data_in   = tx_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass_cnt     = pass_q;
  assign err_cnt      = err_q;
  assign timeout_cnt  = to_q;
  assign last_err_exp = exp_q;
  assign last_err_got = got_q;

`ifdef UART_CHK_STRAY_CNT_EN
  logic [CNT_W-1:0] stray_q, stray_d;

  // Anything but the first echo inside WAIT is a stray byte.
  always_comb begin
    stray_d = stray_q;
    if (state_q == ST_IDLE && start) begin
      stray_d = '0;
    end else if (rx_finish && !(state_q == ST_WAIT && !rx_ok_q)) begin
      stray_d = sat_inc(stray_q);
    end
  end

  always_ff @(posedge clk_out1) begin
    if (rst) begin
      stray_q <= '0;
    end else begin
      stray_q <= stray_d;
    end
  end

  assign stray_cnt = stray_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_echo_checker.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_echo_checker
// Purpose  : Self-checking bench for uart_echo_checker with a board echo model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_echo_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: long timeout, full echo model
  logic        start_a = 1'b0, tx_fin_a = 1'b0, rx_fin_a = 1'b0;
  logic [7:0]  rx_data_a = 8'h00;
  logic        tx_en_a, busy_a, done_a;
  logic [7:0]  tx_data_a, exp_a, got_a;
  logic [15:0] pass_a, err_a, to_a;
  // Instance B: short timeout
  logic        start_b = 1'b0, tx_fin_b = 1'b0, rx_fin_b = 1'b0;
  logic [7:0]  rx_data_b = 8'h00;
  logic        tx_en_b, busy_b, done_b;
  logic [7:0]  tx_data_b, exp_b, got_b;
  logic [15:0] pass_b, err_b, to_b;
`ifdef UART_CHK_STRAY_CNT_EN
  logic [15:0] stray_a, stray_b;
`endif

  uart_echo_checker #(.NUM_BYTES(4), .TIMEOUT_CYCLES(5000), .SEED(8'hA5)) u_dut_a (
    .clk_out1(clk), .rst(rst), .start(start_a),
    .tx_data_en(tx_en_a), .tx_data_in(tx_data_a), .tx_finish(tx_fin_a),
    .rx_finish(rx_fin_a), .rx_data(rx_data_a), .busy(busy_a), .done(done_a),
    .pass_cnt(pass_a), .err_cnt(err_a), .timeout_cnt(to_a),
    .last_err_exp(exp_a), .last_err_got(got_a)
`ifdef UART_CHK_STRAY_CNT_EN
    , .stray_cnt(stray_a)
`endif
  );

  uart_echo_checker #(.NUM_BYTES(4), .TIMEOUT_CYCLES(100), .SEED(8'hA5)) u_dut_b (
    .clk_out1(clk), .rst(rst), .start(start_b),
    .tx_data_en(tx_en_b), .tx_data_in(tx_data_b), .tx_finish(tx_fin_b),
    .rx_finish(rx_fin_b), .rx_data(rx_data_b), .busy(busy_b), .done(done_b),
    .pass_cnt(pass_b), .err_cnt(err_b), .timeout_cnt(to_b),
    .last_err_exp(exp_b), .last_err_got(got_b)
`ifdef UART_CHK_STRAY_CNT_EN
    , .stray_cnt(stray_b)
`endif
  );

  function automatic logic [7:0] model_next(input logic [7:0] l);
    logic fb;
    fb = l[7] ^ l[5] ^ l[4] ^ l[3];
    return {l[6:0], fb};
  endfunction

  // Scoreboard: expected transmit bytes for instance A
  logic [7:0] exp_q[$];

  task automatic push_run(input int n);
    logic [7:0] b;
    b = 8'hA5;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(b);
      b = model_next(b);
    end
  endtask

  // Echo model A: tx_finish 20 cycles after the strobe, echo 1000 later
  int         byte_no_a = 0, corrupt_idx_a = -1, done_cnt_a = 0;
  bit         stray_req_a = 1'b0;
  int         txcd_a = 0, rxcd_a = 0;
  logic [7:0] pend_a = 8'h00;

  initial begin
    forever begin
      @(posedge clk); #1;
      tx_fin_a = 1'b0;
      rx_fin_a = 1'b0;
      if (rst) begin
        txcd_a = 0;
        rxcd_a = 0;
      end else begin
        if (done_a) done_cnt_a++;
        if (stray_req_a) begin
          rx_fin_a    = 1'b1;
          rx_data_a   = 8'h33;
          stray_req_a = 1'b0;
        end
        if (txcd_a > 0) begin
          txcd_a--;
          if (txcd_a == 0) begin
            tx_fin_a = 1'b1;
            rxcd_a   = 1000;
          end
        end
        if (rxcd_a > 0) begin
          rxcd_a--;
          if (rxcd_a == 0) begin
            rx_fin_a  = 1'b1;
            rx_data_a = pend_a;
          end
        end
        if (tx_en_a) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_tx_unexpected: got byte %02h, required no transmission", tx_data_a);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (tx_data_a !== e) begin
              errors++;
              $display("FAIL sb_tx_byte%0d: got %02h, required %02h", byte_no_a, tx_data_a, e);
            end
          end
          pend_a = (byte_no_a == corrupt_idx_a) ? (tx_data_a ^ 8'h01) : tx_data_a;
          txcd_a = 20;
          byte_no_a++;
        end
      end
    end
  end

  // Echo model B: tx_finish after 5 cycles; optional echo in the timeout cycle
  int         byte_no_b = 0, edge_idx_b = -1, done_cnt_b = 0;
  int         txcd_b = 0, rxcd_b = 0;
  logic [7:0] pend_b = 8'h00;

  initial begin
    forever begin
      @(posedge clk); #1;
      tx_fin_b = 1'b0;
      rx_fin_b = 1'b0;
      if (rst) begin
        txcd_b = 0;
        rxcd_b = 0;
      end else begin
        if (done_b) done_cnt_b++;
        if (txcd_b > 0) begin
          txcd_b--;
          if (txcd_b == 0) tx_fin_b = 1'b1;
        end
        if (rxcd_b > 0) begin
          rxcd_b--;
          if (rxcd_b == 0) begin
            rx_fin_b  = 1'b1;
            rx_data_b = pend_b;
          end
        end
        if (tx_en_b) begin
          txcd_b = 5;
          if (byte_no_b == edge_idx_b) begin
            rxcd_b = 99;
            pend_b = tx_data_b;
          end
          byte_no_b++;
        end
      end
    end
  end

  task automatic pulse_start(input bit sel_b);
    @(posedge clk); #2;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #2;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #2;
      if (sel_b ? done_b : done_a) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({busy_a, done_a, tx_en_a, tx_data_a} !== 11'd0) begin
      errors++;
      $display("FAIL reset_ctrl_a: got %b, required 0", {busy_a, done_a, tx_en_a, tx_data_a});
    end
    checks++;
    if ({pass_a, err_a, to_a, exp_a, got_a} !== 64'd0) begin
      errors++;
      $display("FAIL reset_cnt_a: got %h, required 0", {pass_a, err_a, to_a, exp_a, got_a});
    end
    checks++;
    if ({busy_b, done_b, tx_en_b, pass_b, err_b, to_b} !== 51'd0) begin
      errors++;
      $display("FAIL reset_b: got %h, required 0", {busy_b, done_b, tx_en_b, pass_b, err_b, to_b});
    end
    rst = 1'b0;
  endtask

  task automatic run_a_and_check(input string name, input int exp_pass, input int exp_err,
                                 input bit poke_start);
    int cyc;
    byte_no_a  = 0;
    done_cnt_a = 0;
    push_run(4);
    pulse_start(1'b0);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got %b, required 1", name, busy_a);
    end
    if (poke_start) begin
      repeat (1500) @(posedge clk);
      pulse_start(1'b0);
    end
    wait_done(1'b0, 20000, cyc);
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL %s_done_timeout: got no done, required done within budget", name);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({pass_a, err_a, to_a} !== {16'(exp_pass), 16'(exp_err), 16'd0}) begin
      errors++;
      $display("FAIL %s_counts: got pass=%0d err=%0d to=%0d, required pass=%0d err=%0d to=0",
               name, pass_a, err_a, to_a, exp_pass, exp_err);
    end
    checks++;
    if (done_cnt_a !== 1 || busy_a !== 1'b0 || byte_no_a !== 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_end: got done_cycles=%0d busy=%b sent=%0d, required 1/0/4",
               name, done_cnt_a, busy_a, byte_no_a);
    end
  endtask

  task automatic test_pass();
    corrupt_idx_a = -1;
    run_a_and_check("pass", 4, 0, 1'b0);
  endtask

  task automatic test_mismatch();
    corrupt_idx_a = 1;
    run_a_and_check("mismatch", 3, 1, 1'b0);
    checks++;
    if ({exp_a, got_a} !== {8'h4A, 8'h4B}) begin
      errors++;
      $display("FAIL mismatch_last_err: got exp=%02h got=%02h, required 4A/4B", exp_a, got_a);
    end
    corrupt_idx_a = -1;
  endtask

  task automatic test_start_while_busy();
    run_a_and_check("start_busy", 4, 0, 1'b1);
  endtask

  task automatic test_timeout();
    int cyc;
    edge_idx_b = -1;
    byte_no_b  = 0;
    done_cnt_b = 0;
    pulse_start(1'b1);
    wait_done(1'b1, 2000, cyc);
    checks++;
    if (cyc < 404 || cyc > 416) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles, required about 408", cyc);
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({pass_b, err_b, to_b} !== {16'd0, 16'd0, 16'd4} || done_cnt_b !== 1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL timeout_counts: got pass=%0d err=%0d to=%0d done=%0d, required 0/0/4/1",
               pass_b, err_b, to_b, done_cnt_b);
    end
  endtask

  task automatic test_timeout_edge();
    int cyc;
    edge_idx_b = 0;
    byte_no_b  = 0;
    pulse_start(1'b1);
    wait_done(1'b1, 2000, cyc);
    #1;
    checks++;
    if (cyc < 0 || {pass_b, err_b, to_b} !== {16'd1, 16'd0, 16'd3}) begin
      errors++;
      $display("FAIL timeout_edge: got pass=%0d err=%0d to=%0d, required 1/0/3", pass_b, err_b, to_b);
    end
    edge_idx_b = -1;
  endtask

  task automatic test_stray();
    int sent;
    logic [15:0] p;
`ifdef UART_CHK_STRAY_CNT_EN
    logic [15:0] s;
    s = stray_a;
`endif
    sent = byte_no_a;
    p = pass_a;
    stray_req_a = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    checks++;
    if (busy_a !== 1'b0 || byte_no_a !== sent || pass_a !== p) begin
      errors++;
      $display("FAIL stray_idle: got busy=%b sent=%0d pass=%0d, required 0/%0d/%0d",
               busy_a, byte_no_a, pass_a, sent, p);
    end
`ifdef UART_CHK_STRAY_CNT_EN
    checks++;
    if (stray_a !== s + 16'd1) begin
      errors++;
      $display("FAIL stray_cnt: got %0d, required %0d", stray_a, s + 16'd1);
    end
`endif
  endtask

  task automatic test_mid_reset();
    int d;
    byte_no_a  = 0;
    done_cnt_a = 0;
    push_run(4);
    pulse_start(1'b0);
    for (int i = 0; i < 5000 && byte_no_a < 2; i++) @(posedge clk);
    repeat (50) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    checks++;
    if ({busy_a, done_a, tx_en_a, tx_data_a, pass_a, err_a, to_a, exp_a, got_a} !== 75'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h, required 0",
               {busy_a, done_a, tx_en_a, tx_data_a, pass_a, err_a, to_a, exp_a, got_a});
    end
    exp_q.delete();
    d = done_cnt_a;
    repeat (20) @(posedge clk);
    checks++;
    if (done_cnt_a !== d || byte_no_a !== 2) begin
      errors++;
      $display("FAIL midrst_quiet: got done=%0d sent=%0d, required %0d/2", done_cnt_a, byte_no_a, d);
    end
    run_a_and_check("after_rst", 4, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_start_while_busy();
    test_timeout();
    test_timeout_edge();
    test_stray();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
